// File: rtl/systolic_pkg.sv
// Shared constants and state type for the 3x4 systolic bank and its sequencer.
package systolic_pkg;

  localparam int unsigned N_COLS = 4;
  localparam int unsigned N_ROWS = 3;
  localparam int unsigned IWIDTH = 16;
  localparam int unsigned OWIDTH = 33;
  localparam int unsigned PE_LAT = 3;
  localparam int unsigned AC_LAT = 1;
  localparam int unsigned BEAT_W = 16;

  // Bus widths for the packed row/feature/column buses (element 1 in LSBs).
  localparam int unsigned W_BUS = N_ROWS * IWIDTH;
  localparam int unsigned F_BUS = (N_ROWS + N_COLS - 1) * IWIDTH;
  localparam int unsigned D_BUS = N_COLS * OWIDTH;

  // Cycles between the last in_en beat and the edge that captures every column.
  localparam int unsigned DRAIN_CYC = PE_LAT + N_COLS - 1 + AC_LAT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_STREAM,
    ST_DRAIN,
    ST_OUT
  } seq_state_e;

endpackage

// File: rtl/systolic_bank_sequencer_skew_line.sv
// One-bit delay line; tap k carries din delayed by LEAD+k cycles.
module skew_line #(
  parameter int unsigned LEAD   = 3,
  parameter int unsigned N_TAPS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [N_TAPS-1:0] taps
);

  localparam int unsigned DEPTH = LEAD + N_TAPS - 1;

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  // Advance the line by one position; bit k holds din from k+1 cycles ago.
  always_comb begin
    line_d = {line_q[DEPTH-2:0], din};
  end

  // Line storage, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign taps = line_q[LEAD-1 +: N_TAPS];

endmodule

// File: rtl/systolic_bank_sequencer.sv
// Job/beat sequencer for the 3x4 systolic bank: configures the bank, streams
// beats, generates skewed per-column G/F strobes, captures column results.
module systolic_bank_sequencer
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [BEAT_W-1:0] job_beats,
  input  logic [N_ROWS-1:0] job_config,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [W_BUS-1:0]  src_weight,
  input  logic [F_BUS-1:0]  src_feature,
  output logic              bank_in_en,
  output logic              bank_config_load,
  output logic [N_ROWS-1:0] bank_iconfig,
  output logic [W_BUS-1:0]  bank_weight,
  output logic [F_BUS-1:0]  bank_feature,
  output logic [N_COLS-1:0] bank_g,
  output logic [N_COLS-1:0] bank_f,
  input  logic [D_BUS-1:0]  bank_dout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [D_BUS-1:0]  res_data
);

  seq_state_e        state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [N_ROWS-1:0] cfg_q, cfg_d;
  logic              job_ready_q, job_ready_d;
  logic              src_ready_q, src_ready_d;
  logic              config_load_q, config_load_d;
  logic              in_en_q, in_en_d;
  logic              last_q, last_d;
  logic [W_BUS-1:0]  weight_q, weight_d;
  logic [F_BUS-1:0]  feature_q, feature_d;
  logic              res_valid_q, res_valid_d;
  logic [D_BUS-1:0]  res_data_q, res_data_d;

  // Next-state and registered-output logic; cnt_q counts beats in STREAM and
  // is reloaded with the drain wait on the last beat.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cfg_d         = cfg_q;
    job_ready_d   = job_ready_q;
    src_ready_d   = src_ready_q;
    config_load_d = 1'b0;
    in_en_d       = 1'b0;
    last_d        = 1'b0;
    weight_d      = weight_q;
    feature_d     = feature_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    case (state_q)
      ST_IDLE: begin
        job_ready_d = 1'b1;
        if (job_valid && job_ready_q) begin
          cfg_d       = job_config;
          job_ready_d = 1'b0;
          if (job_beats != '0) begin
            cnt_d         = job_beats;
            config_load_d = 1'b1;
            state_d       = ST_CONFIG;
          end else begin
            res_data_d  = '0;
            res_valid_d = 1'b1;
            state_d     = ST_OUT;
          end
        end
      end
      ST_CONFIG: begin
        src_ready_d = 1'b1;
        state_d     = ST_STREAM;
      end
      ST_STREAM: begin
        if (src_valid && src_ready_q) begin
          weight_d  = src_weight;
          feature_d = src_feature;
          in_en_d   = 1'b1;
          if (cnt_q == BEAT_W'(1)) begin
            last_d      = 1'b1;
            src_ready_d = 1'b0;
            cnt_d       = BEAT_W'(DRAIN_CYC);
            state_d     = ST_DRAIN;
          end else begin
            cnt_d = cnt_q - BEAT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          res_data_d  = bank_dout;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          cnt_d = cnt_q - BEAT_W'(1);
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          job_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers; job_ready comes out of reset high since IDLE accepts jobs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cfg_q         <= '0;
      job_ready_q   <= 1'b1;
      src_ready_q   <= 1'b0;
      config_load_q <= 1'b0;
      in_en_q       <= 1'b0;
      last_q        <= 1'b0;
      weight_q      <= '0;
      feature_q     <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cfg_q         <= cfg_d;
      job_ready_q   <= job_ready_d;
      src_ready_q   <= src_ready_d;
      config_load_q <= config_load_d;
      in_en_q       <= in_en_d;
      last_q        <= last_d;
      weight_q      <= weight_d;
      feature_q     <= feature_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
    end
  end

  skew_line #(.LEAD(PE_LAT), .N_TAPS(N_COLS)) u_g_line (
    .clk  (clk),
    .rst  (rst),
    .din  (in_en_q),
    .taps (bank_g)
  );

  skew_line #(.LEAD(PE_LAT), .N_TAPS(N_COLS)) u_f_line (
    .clk  (clk),
    .rst  (rst),
    .din  (last_q),
    .taps (bank_f)
  );

  assign job_ready        = job_ready_q;
  assign src_ready        = src_ready_q;
  assign bank_in_en       = in_en_q;
  assign bank_config_load = config_load_q;
  assign bank_iconfig     = cfg_q;
  assign bank_weight      = weight_q;
  assign bank_feature     = feature_q;
  assign res_valid        = res_valid_q;
  assign res_data         = res_data_q;

endmodule
